// File: rtl/mem_ctrl_pkg.sv
// Shared types and decode helpers for the byte-serial memory controller.
// Holds instruction-type encodings, FSM states and the pending-request record.
package mem_ctrl_pkg;

  localparam int ADDRESS_WIDTH     = 32;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int INST_TYPE_WIDTH   = 4;

  localparam logic [INST_TYPE_WIDTH-1:0] INST_LB  = 4'd0;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_LH  = 4'd1;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_LW  = 4'd2;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_LBU = 4'd3;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_LHU = 4'd4;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_SB  = 4'd5;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_SH  = 4'd6;
  localparam logic [INST_TYPE_WIDTH-1:0] INST_SW  = 4'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STORE = 2'd1,
    S_LOAD  = 2'd2,
    S_FETCH = 2'd3
  } state_t;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0]     addr;
    logic [INST_TYPE_WIDTH-1:0]   itype;
    logic [INSTRUCTION_WIDTH-1:0] data;
  } req_t;

  function automatic logic [2:0] byte_count(input logic [INST_TYPE_WIDTH-1:0] itype);
    case (itype)
      INST_SB, INST_LB, INST_LBU: byte_count = 3'd1;
      INST_SH, INST_LH, INST_LHU: byte_count = 3'd2;
      default:                    byte_count = 3'd4;
    endcase
  endfunction

  function automatic logic [INSTRUCTION_WIDTH-1:0] load_extend(
    input logic [INST_TYPE_WIDTH-1:0]   itype,
    input logic [INSTRUCTION_WIDTH-1:0] raw
  );
    case (itype)
      INST_LB:  load_extend = {{24{raw[7]}}, raw[7:0]};
      INST_LBU: load_extend = {24'd0, raw[7:0]};
      INST_LH:  load_extend = {{16{raw[15]}}, raw[15:0]};
      INST_LHU: load_extend = {16'd0, raw[15:0]};
      default:  load_extend = raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_slot.sv
// Pending-request latch: captures one request and holds it until the
// arbiter takes it, or until a flush discards it.
module mem_req_slot
  import mem_ctrl_pkg::*;
(
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic set,
  input  logic clr,
  input  logic flush_clr,
  input  req_t req_next,
  output logic valid,
  output req_t req
);

  // A flush in the same cycle as the set pulse wins, so the request is dropped.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid <= 1'b0;
      req   <= '0;
    end else if (rdy_in) begin
      if (flush_clr || clr) begin
        valid <= 1'b0;
      end else if (set && !valid) begin
        valid <= 1'b1;
        req   <= req_next;
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating ROB stores, load-buffer loads and
// instruction fetches onto an 8-bit synchronous RAM port.
//
// state   | meaning
// S_IDLE  | waiting; picks store > load > fetch from the pending slots
// S_STORE | driving one write byte per cycle, then finish pulse
// S_LOAD  | issuing read addresses, capturing bytes one cycle later
// S_FETCH | as S_LOAD, always 4 bytes, no extension
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush,
  input  logic                         rob_en_in,
  input  logic [ADDRESS_WIDTH-1:0]     rob_address_in,
  input  logic [INSTRUCTION_WIDTH-1:0] rob_wdata_in,
  input  logic [INST_TYPE_WIDTH-1:0]   rob_inst_type_in,
  output logic                         rob_rdy_out,
  output logic                         rob_finish_out,
  input  logic                         lbuffer_en_in,
  input  logic [ADDRESS_WIDTH-1:0]     lbuffer_address_in,
  input  logic [INST_TYPE_WIDTH-1:0]   lbuffer_inst_type_in,
  output logic                         lbuffer_finish_out,
  output logic [INSTRUCTION_WIDTH-1:0] lbuffer_data_out,
  input  logic                         if_en_in,
  input  logic [ADDRESS_WIDTH-1:0]     if_pc_in,
  output logic                         if_finish_out,
  output logic [INSTRUCTION_WIDTH-1:0] if_inst_out,
  input  logic [7:0]                   mem_din_in,
  output logic [7:0]                   mem_dout_out,
  output logic [31:0]                  mem_a_out,
  output logic                         mem_wr_out
);

  req_t store_next, load_next, fetch_next;
  req_t store_req, load_req, fetch_req;
  logic store_valid, load_valid, fetch_valid;
  logic store_clr, load_clr, fetch_clr;

  assign store_next = '{addr: rob_address_in, itype: rob_inst_type_in, data: rob_wdata_in};
  assign load_next  = '{addr: lbuffer_address_in, itype: lbuffer_inst_type_in, data: '0};
  assign fetch_next = '{addr: if_pc_in, itype: INST_LW, data: '0};

  // Stores are already committed, so a flush never touches the store slot.
  mem_req_slot u_store_slot (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .set       (rob_en_in),
    .clr       (store_clr),
    .flush_clr (1'b0),
    .req_next  (store_next),
    .valid     (store_valid),
    .req       (store_req)
  );

  mem_req_slot u_load_slot (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .set       (lbuffer_en_in),
    .clr       (load_clr),
    .flush_clr (flush),
    .req_next  (load_next),
    .valid     (load_valid),
    .req       (load_req)
  );

  mem_req_slot u_fetch_slot (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .set       (if_en_in),
    .clr       (fetch_clr),
    .flush_clr (flush),
    .req_next  (fetch_next),
    .valid     (fetch_valid),
    .req       (fetch_req)
  );

  state_t                       state_q, state_d;
  logic [2:0]                   cnt_q, cnt_d;
  req_t                         cur_q, cur_d;
  logic [INSTRUCTION_WIDTH-1:0] asm_q, asm_d, asm_cap;
  logic [2:0]                   nbytes;
  logic [1:0]                   cap_idx;
  logic [31:0]                  byte_addr;

  logic                         rob_finish_q, rob_finish_d;
  logic                         lb_finish_q, lb_finish_d;
  logic                         if_finish_q, if_finish_d;
  logic [INSTRUCTION_WIDTH-1:0] lb_data_q, lb_data_d;
  logic [INSTRUCTION_WIDTH-1:0] if_inst_q, if_inst_d;
  logic [31:0]                  a_q, a_d;
  logic [7:0]                   dout_q, dout_d;
  logic                         wr_q, wr_d;

  // Read data lags its address by one cycle, so byte k lands when cnt_q = k+2.
  always_comb begin
    nbytes    = (state_q == S_FETCH) ? 3'd4 : byte_count(cur_q.itype);
    cap_idx   = cnt_q[1:0] - 2'd2;
    byte_addr = cur_q.addr + {29'd0, cnt_q};
    asm_cap   = asm_q;
    asm_cap[{cap_idx, 3'b000} +: 8] = mem_din_in;

    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_d        = cur_q;
    asm_d        = asm_q;
    store_clr    = 1'b0;
    load_clr     = 1'b0;
    fetch_clr    = 1'b0;
    rob_finish_d = 1'b0;
    lb_finish_d  = 1'b0;
    if_finish_d  = 1'b0;
    lb_data_d    = lb_data_q;
    if_inst_d    = if_inst_q;
    a_d          = a_q;
    dout_d       = dout_q;
    wr_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (store_valid) begin
          store_clr = 1'b1;
          cur_d     = store_req;
          cnt_d     = 3'd0;
          state_d   = S_STORE;
        end else if (load_valid && !flush) begin
          load_clr = 1'b1;
          cur_d    = load_req;
          cnt_d    = 3'd0;
          asm_d    = '0;
          state_d  = S_LOAD;
        end else if (fetch_valid && !flush) begin
          fetch_clr = 1'b1;
          cur_d     = fetch_req;
          cnt_d     = 3'd0;
          asm_d     = '0;
          state_d   = S_FETCH;
        end
      end

      S_STORE: begin
        if (cnt_q == nbytes) begin
          rob_finish_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          a_d    = byte_addr;
          dout_d = cur_q.data[{cnt_q[1:0], 3'b000} +: 8];
          wr_d   = 1'b1;
          cnt_d  = cnt_q + 3'd1;
        end
      end

      S_LOAD, S_FETCH: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (cnt_q < nbytes) begin
            a_d = byte_addr;
          end
          if (cnt_q >= 3'd2) begin
            asm_d = asm_cap;
          end
          if (cnt_q == nbytes + 3'd1) begin
            state_d = S_IDLE;
            if (state_q == S_LOAD) begin
              lb_finish_d = 1'b1;
              lb_data_d   = load_extend(cur_q.itype, asm_cap);
            end else begin
              if_finish_d = 1'b1;
              if_inst_d   = asm_cap;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cur_q        <= '0;
      asm_q        <= '0;
      rob_finish_q <= 1'b0;
      lb_finish_q  <= 1'b0;
      if_finish_q  <= 1'b0;
      lb_data_q    <= '0;
      if_inst_q    <= '0;
      a_q          <= '0;
      dout_q       <= '0;
      wr_q         <= 1'b0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      asm_q        <= asm_d;
      rob_finish_q <= rob_finish_d;
      lb_finish_q  <= lb_finish_d;
      if_finish_q  <= if_finish_d;
      lb_data_q    <= lb_data_d;
      if_inst_q    <= if_inst_d;
      a_q          <= a_d;
      dout_q       <= dout_d;
      wr_q         <= wr_d;
    end
  end

  assign rob_finish_out     = rob_finish_q;
  assign lbuffer_finish_out = lb_finish_q;
  assign lbuffer_data_out   = lb_data_q;
  assign if_finish_out      = if_finish_q;
  assign if_inst_out        = if_inst_q;
  assign mem_a_out          = a_q;
  assign mem_dout_out       = dout_q;
  // A held write byte must not be repeated into RAM while stalled.
  assign mem_wr_out         = wr_q & rdy_in;
  assign rob_rdy_out        = !store_valid && (state_q != S_STORE) && !rob_finish_q;

endmodule
